dtack_generator: RTL and testbench

- Initiator-side companion to the single-step DTACK gate.
- Watches the 68000 bus strobes and decodes selected cycles.
- Raises an execute request (ENABLE_OUT), waits for the step gate's grant (ENABLE_EXECUTE_IN), inserts programmable wait states, then drives DTACK_N until the CPU ends the cycle.
- Optional bus-error watchdog terminates cycles that never receive a grant.

---
 rtl/dtack_generator.sv | 195 +++++++++++++++++++
 tb/tb_dtack_generator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dtack_generator.sv
// DTACK generator: decodes selected 68000 bus cycles, requests execution from the
// step gate, inserts wait states, then acknowledges. Optional watchdog: DTACK_GENERATOR_BUS_TIMEOUT_EN.
module dtack_generator #(
  parameter int WAIT_STATES  = 2,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       AS_N_IN,
  input  logic       UDS_N_IN,
  input  logic       LDS_N_IN,
  input  logic       RW_IN,
  input  logic       SEL_IN,
  input  logic       STEPEN_IN,
  input  logic       ENABLE_EXECUTE_IN,
  output logic       ENABLE_OUT,
  output logic       DTACK_N_OUT,
  output logic       BERR_N_OUT,
  output logic       WRITE_PULSE_OUT,
  output logic [2:0] STATE_OUT
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_BERR    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0] as_sync_r, uds_sync_r, lds_sync_r, rw_sync_r;
  logic       as_act_s, ds_act_s, rw_s;
  state_t     state_r, state_nx_s;
  logic [3:0] wait_cnt_r, wait_cnt_nx_s;
  logic       rw_lat_r, rw_lat_nx_s;
  logic       enable_r, dtack_n_r, write_pulse_r;
  logic       enable_nx_s, dtack_n_nx_s, write_pulse_nx_s;
  logic       timeout_s;

  // Two-flop synchronizers for the asynchronous bus strobes; idle level is high.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      as_sync_r  <= 2'b11;
      uds_sync_r <= 2'b11;
      lds_sync_r <= 2'b11;
      rw_sync_r  <= 2'b11;
    end else begin
      as_sync_r  <= {as_sync_r[0], AS_N_IN};
      uds_sync_r <= {uds_sync_r[0], UDS_N_IN};
      lds_sync_r <= {lds_sync_r[0], LDS_N_IN};
      rw_sync_r  <= {rw_sync_r[0], RW_IN};
    end
  end

  assign as_act_s = ~as_sync_r[1];
  assign ds_act_s = ~uds_sync_r[1] | ~lds_sync_r[1];
  assign rw_s     = rw_sync_r[1];

`ifdef DTACK_GENERATOR_BUS_TIMEOUT_EN
  // Hit one count early so BERR lands on the edge the counter would reach all-ones.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = ~(TIMEOUT_BITS'(1));

  logic [TIMEOUT_BITS-1:0] wd_cnt_r;
  logic                    berr_n_r, berr_n_nx_s;

  // Watchdog: cleared on REQ entry and while stepping, counts cycles spent in REQ.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      wd_cnt_r <= '0;
    end else if (STEPEN_IN || (state_nx_s == ST_REQ && state_r != ST_REQ)) begin
      wd_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      wd_cnt_r <= wd_cnt_r + TIMEOUT_BITS'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign timeout_s   = (wd_cnt_r == WD_LAST) && !STEPEN_IN;
  assign berr_n_nx_s = (state_nx_s != ST_BERR);

  // Bus-error output register.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      berr_n_r <= 1'b1;
    end else begin
      berr_n_r <= berr_n_nx_s;
    end
  end

  assign BERR_N_OUT = berr_n_r;
`else
  logic unused_s;
  assign unused_s   = STEPEN_IN ^ (TIMEOUT_BITS > 0);
  assign timeout_s  = 1'b0;
  assign BERR_N_OUT = 1'b1;
`endif

  // Next-state, wait counter and RW latch.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    rw_lat_nx_s   = rw_lat_r;
    case (state_r)
      ST_IDLE: begin
        if (as_act_s) begin
          if (!SEL_IN) begin
            state_nx_s = ST_RECOVER;
          end else if (ds_act_s) begin
            state_nx_s  = ST_REQ;
            rw_lat_nx_s = rw_s;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Abort beats grant when both arrive together.
        if (!as_act_s) begin
          state_nx_s = ST_RECOVER;
        end else if (ENABLE_EXECUTE_IN) begin
          if (WAIT_LOAD == 4'd0) begin
            state_nx_s = ST_ACK;
          end else begin
            state_nx_s    = ST_WAIT;
            wait_cnt_nx_s = WAIT_LOAD;
          end
        end else if (timeout_s) begin
          state_nx_s = ST_BERR;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (!as_act_s) begin
          state_nx_s    = ST_RECOVER;
          wait_cnt_nx_s = 4'd0;
        end else if (wait_cnt_r <= 4'd1) begin
          state_nx_s    = ST_ACK;
          wait_cnt_nx_s = 4'd0;
        end else begin
          wait_cnt_nx_s = wait_cnt_r - 4'd1;
        end
      end
      ST_ACK, ST_BERR, ST_RECOVER: begin
        if (!as_act_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        wait_cnt_nx_s = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    enable_nx_s      = (state_nx_s == ST_REQ) || (state_nx_s == ST_WAIT) || (state_nx_s == ST_ACK);
    dtack_n_nx_s     = (state_nx_s != ST_ACK);
    write_pulse_nx_s = (state_nx_s == ST_ACK) && (state_r != ST_ACK) && !rw_lat_nx_s;
  end

  // State, counter and output registers.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 4'd0;
      rw_lat_r      <= 1'b1;
      enable_r      <= 1'b0;
      dtack_n_r     <= 1'b1;
      write_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      wait_cnt_r    <= wait_cnt_nx_s;
      rw_lat_r      <= rw_lat_nx_s;
      enable_r      <= enable_nx_s;
      dtack_n_r     <= dtack_n_nx_s;
      write_pulse_r <= write_pulse_nx_s;
    end
  end

  assign ENABLE_OUT      = enable_r;
  assign DTACK_N_OUT     = dtack_n_r;
  assign WRITE_PULSE_OUT = write_pulse_r;
  assign STATE_OUT       = state_r;

endmodule

// File: tb/tb_dtack_generator.sv
// Directed bench for dtack_generator: one instance with 2 wait states, one with none.
module tb_dtack_generator;

  // Observation vector: {ENABLE, DTACK_N, BERR_N, WRITE_PULSE, STATE[2:0]}
  localparam logic [6:0] V_IDLE    = 7'b0110_000;
  localparam logic [6:0] V_REQ     = 7'b1110_001;
  localparam logic [6:0] V_WAIT    = 7'b1110_010;
  localparam logic [6:0] V_ACK     = 7'b1010_011;
  localparam logic [6:0] V_ACK_WR  = 7'b1011_011;
  localparam logic [6:0] V_BERR    = 7'b0100_100;
  localparam logic [6:0] V_RECOVER = 7'b0110_101;

  typedef struct {
    string      tag;
    int         idx;
    logic [6:0] exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst, as_n, uds_n, lds_n, rw, sel, sel0, stepen, grant;
  logic en_a, dtack_a, berr_a, wp_a;
  logic en_b, dtack_b, berr_b, wp_b;
  logic [2:0] st_a, st_b;
  logic [6:0] obs_a, obs_b;
  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtack_generator #(.WAIT_STATES(2), .TIMEOUT_BITS(4)) dut (
    .MCLK_IN(clk), .RESET_IN(rst), .AS_N_IN(as_n), .UDS_N_IN(uds_n), .LDS_N_IN(lds_n),
    .RW_IN(rw), .SEL_IN(sel), .STEPEN_IN(stepen), .ENABLE_EXECUTE_IN(grant),
    .ENABLE_OUT(en_a), .DTACK_N_OUT(dtack_a), .BERR_N_OUT(berr_a),
    .WRITE_PULSE_OUT(wp_a), .STATE_OUT(st_a)
  );

  dtack_generator #(.WAIT_STATES(0), .TIMEOUT_BITS(4)) dut0 (
    .MCLK_IN(clk), .RESET_IN(rst), .AS_N_IN(as_n), .UDS_N_IN(uds_n), .LDS_N_IN(lds_n),
    .RW_IN(rw), .SEL_IN(sel0), .STEPEN_IN(stepen), .ENABLE_EXECUTE_IN(grant),
    .ENABLE_OUT(en_b), .DTACK_N_OUT(dtack_b), .BERR_N_OUT(berr_b),
    .WRITE_PULSE_OUT(wp_b), .STATE_OUT(st_b)
  );

  assign obs_a = {en_a, dtack_a, berr_a, wp_a, st_a};
  assign obs_b = {en_b, dtack_b, berr_b, wp_b, st_b};

  task automatic check_front();
    sb_item_t it;
    logic [6:0] obs;
    it  = sb.pop_front();
    obs = (it.idx == 0) ? obs_a : obs_b;
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
    end
  endtask

  // Queue an expectation, let n clock edges pass (sampling 1 time unit after), then compare.
  task automatic expect_after(input int n, input int idx, input string tag, input logic [6:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.idx = idx;
    it.exp = exp;
    sb.push_back(it);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check_front();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    sel = 1'b0; sel0 = 1'b0; stepen = 1'b0; grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expect_after(0, 0, "rst_idle_a", V_IDLE);
    expect_after(0, 1, "rst_idle_b", V_IDLE);

    // Read cycle, grant already high, two wait states.
    sel = 1'b1; grant = 1'b1; rw = 1'b1;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    expect_after(2, 0, "rd_pre_req", V_IDLE);
    expect_after(1, 0, "rd_req", V_REQ);
    expect_after(1, 0, "rd_wait_a", V_WAIT);
    expect_after(1, 0, "rd_wait_b", V_WAIT);
    expect_after(1, 0, "rd_ack", V_ACK);
    grant = 1'b0;
    expect_after(2, 0, "rd_ack_grant_drop", V_ACK);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    expect_after(2, 0, "rd_ack_tail", V_ACK);
    expect_after(1, 0, "rd_release", V_IDLE);
    tick();

    // Write on the zero-wait instance while the other one is not selected.
    sel = 1'b0; sel0 = 1'b1; grant = 1'b1; rw = 1'b0;
    as_n = 1'b0; lds_n = 1'b0;
    expect_after(3, 1, "wr_req", V_REQ);
    expect_after(0, 0, "nosel_recover", V_RECOVER);
    expect_after(1, 1, "wr_ack_pulse", V_ACK_WR);
    expect_after(1, 1, "wr_ack_no_pulse", V_ACK);
    expect_after(0, 0, "nosel_quiet", V_RECOVER);
    as_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    tick();

    // Immediately a selected read on the first instance.
    sel = 1'b1; sel0 = 1'b0;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    expect_after(2, 0, "b2b_idle", V_IDLE);
    expect_after(0, 1, "wr_release", V_IDLE);
    expect_after(1, 0, "b2b_req", V_REQ);
    expect_after(3, 0, "b2b_ack", V_ACK);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    expect_after(3, 0, "b2b_release", V_IDLE);
    tick();

    // Aborted cycle: AS negated while waiting for grant.
    grant = 1'b0; stepen = 1'b0;
    as_n = 1'b0; uds_n = 1'b0;
    expect_after(3, 0, "ab_req", V_REQ);
    expect_after(5, 0, "ab_hold", V_REQ);
    as_n = 1'b1; uds_n = 1'b1;
    expect_after(2, 0, "ab_still_req", V_REQ);
    expect_after(1, 0, "ab_recover", V_RECOVER);
    expect_after(1, 0, "ab_idle", V_IDLE);
    tick();

    // Stepper mode: grant withheld for thousands of cycles.
    stepen = 1'b1; grant = 1'b0;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    expect_after(3, 0, "st_req", V_REQ);
    for (int k = 0; k < 5; k++) begin
      expect_after(1000, 0, "st_hold_req", V_REQ);
    end
    grant = 1'b1;
    expect_after(2, 0, "st_wait", V_WAIT);
    expect_after(1, 0, "st_ack", V_ACK);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; grant = 1'b0; stepen = 1'b0;
    expect_after(3, 0, "st_release", V_IDLE);
    tick();

    // Grant never arrives with stepping off.
    as_n = 1'b0; uds_n = 1'b0;
    expect_after(3, 0, "to_req", V_REQ);
`ifdef DTACK_GENERATOR_BUS_TIMEOUT_EN
    expect_after(14, 0, "to_req_last", V_REQ);
    expect_after(1, 0, "to_berr", V_BERR);
    expect_after(4, 0, "to_berr_hold", V_BERR);
    as_n = 1'b1; uds_n = 1'b1;
    expect_after(2, 0, "to_berr_tail", V_BERR);
    expect_after(1, 0, "to_idle", V_IDLE);
`else
    expect_after(40, 0, "nto_req_hold", V_REQ);
    as_n = 1'b1; uds_n = 1'b1;
    expect_after(3, 0, "nto_recover", V_RECOVER);
    expect_after(1, 0, "nto_idle", V_IDLE);
`endif
    tick();

    // Reset pulsed mid-cycle while acknowledging.
    grant = 1'b1;
    as_n = 1'b0; uds_n = 1'b0;
    expect_after(3, 0, "rs_req", V_REQ);
    expect_after(3, 0, "rs_ack", V_ACK);
    #3;
    rst = 1'b1;
    #1;
    expect_after(0, 0, "rs_async_a", V_IDLE);
    expect_after(0, 1, "rs_async_b", V_IDLE);
    as_n = 1'b1; uds_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    as_n = 1'b0; uds_n = 1'b0;
    expect_after(2, 0, "rs_restart_idle", V_IDLE);
    expect_after(1, 0, "rs_restart_req", V_REQ);
    expect_after(3, 0, "rs_restart_ack", V_ACK);
    as_n = 1'b1; uds_n = 1'b1;
    expect_after(3, 0, "rs_restart_release", V_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
